// File: rtl/usb_fs_rx.sv
// usb_fs_rx: full-speed USB receive front end. Recovers bit timing at 4x oversampling,
// then NRZI-decodes, de-stuffs and frames bytes, and detects SYNC, EOP and bus reset.
module usb_fs_rx #(
  parameter int CLKS_PER_BIT   = 4,
  parameter int SAMPLE_PHASE   = 1,
  parameter int RESET_SE0_CLKS = 120
) (
  input  logic       clk48,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       rx_j,
  input  logic       rx_se0,
  output logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_eop,
  output logic       rx_err,
  output logic       usb_rst
);

  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(SAMPLE_PHASE);
  localparam int SW = $clog2(RESET_SE0_CLKS + 1);
  localparam logic [SW-1:0] SE0_LAST = SW'(RESET_SE0_CLKS - 1);
  localparam logic [SW-1:0] SE0_MAX  = SW'(RESET_SE0_CLKS);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP,
    ERR_WAIT
  } state_t;

  logic          j_meta, j_sync, se0_meta, se0_sync;
  logic [1:0]    line, line_q;
  logic [PW-1:0] phase;
  logic          sample;
  logic          bit_dec;
  logic          prev_j;
  logic          hold;
  logic [SW-1:0] se0_cnt;

  state_t     state, state_n;
  logic [2:0] zero_cnt, zero_n;
  logic [2:0] bit_cnt, bit_n;
  logic [2:0] ones_cnt, ones_n;
  logic [2:0] idle_cnt, idle_n;
  logic [7:0] shift_q, shift_n;
  logic [7:0] data_n;
  logic       valid_n, eop_n, err_n;

  // Two-flop synchronisers; they come out of reset showing an idle (J) bus.
  always_ff @(posedge clk48 or negedge rst) begin
    if (!rst) begin
      j_meta   <= 1'b1;
      j_sync   <= 1'b1;
      se0_meta <= 1'b0;
      se0_sync <= 1'b0;
    end else begin
      j_meta   <= rx_j;
      j_sync   <= j_meta;
      se0_meta <= rx_se0;
      se0_sync <= se0_meta;
    end
  end

  // Line state code: 2'b10 = SE0, 2'b01 = J, 2'b00 = K.
  assign line    = se0_sync ? 2'b10 : {1'b0, j_sync};
  assign sample  = (phase == PH_SAMPLE);
  assign bit_dec = (j_sync == prev_j);
  assign hold    = tx_en | usb_rst;

  // Each line transition realigns the phase so sampling lands mid-bit.
  always_ff @(posedge clk48 or negedge rst) begin
    if (!rst) begin
      line_q <= 2'b01;
      phase  <= '0;
    end else begin
      line_q <= line;
      if (line != line_q)
        phase <= '0;
      else if (phase == PH_LAST)
        phase <= '0;
      else
        phase <= phase + 1'b1;
    end
  end

  always_ff @(posedge clk48 or negedge rst) begin
    if (!rst) begin
      se0_cnt <= '0;
      usb_rst <= 1'b0;
    end else if (!se0_sync) begin
      se0_cnt <= '0;
      usb_rst <= 1'b0;
    end else begin
      if (se0_cnt != SE0_MAX)
        se0_cnt <= se0_cnt + 1'b1;
      if (se0_cnt == SE0_LAST)
        usb_rst <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    zero_n  = zero_cnt;
    bit_n   = bit_cnt;
    ones_n  = ones_cnt;
    idle_n  = idle_cnt;
    shift_n = shift_q;
    data_n  = rx_data;
    valid_n = 1'b0;
    eop_n   = 1'b0;
    err_n   = 1'b0;

    if (sample) begin
      case (state)
        IDLE: begin
          if (!se0_sync && !j_sync) begin
            state_n = SYNC;
            zero_n  = 3'd1;
          end
        end
        SYNC: begin
          if (se0_sync) begin
            state_n = ERR_WAIT;
            err_n   = 1'b1;
          end else if (!bit_dec) begin
            if (zero_cnt != 3'd7)
              zero_n = zero_cnt + 3'd1;
          end else if (zero_cnt >= 3'd3) begin
            state_n = DATA;
            bit_n   = 3'd0;
            ones_n  = 3'd0;
          end else begin
            state_n = ERR_WAIT;
            err_n   = 1'b1;
          end
        end
        DATA: begin
          // A single dribble bit before SE0 is tolerated and dropped.
          if (se0_sync) begin
            if (bit_cnt <= 3'd1) begin
              state_n = EOP;
            end else begin
              state_n = ERR_WAIT;
              err_n   = 1'b1;
            end
          end else if (ones_cnt == 3'd6) begin
            if (bit_dec) begin
              state_n = ERR_WAIT;
              err_n   = 1'b1;
            end else begin
              ones_n = 3'd0;
            end
          end else begin
            shift_n = {bit_dec, shift_q[7:1]};
            ones_n  = bit_dec ? ones_cnt + 3'd1 : 3'd0;
            bit_n   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              data_n  = {bit_dec, shift_q[7:1]};
              valid_n = 1'b1;
            end
          end
        end
        EOP: begin
          if (!se0_sync) begin
            if (j_sync) begin
              state_n = IDLE;
              eop_n   = 1'b1;
            end else begin
              state_n = ERR_WAIT;
              err_n   = 1'b1;
            end
          end
        end
        ERR_WAIT: begin
          if (!se0_sync && j_sync) begin
            if (idle_cnt == 3'd7) begin
              state_n = IDLE;
              idle_n  = 3'd0;
            end else begin
              idle_n = idle_cnt + 3'd1;
            end
          end else begin
            idle_n = 3'd0;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (err_n)
      idle_n = 3'd0;

    // Our own transmitter or a bus reset owns the line: drop any packet silently.
    if (hold) begin
      state_n = IDLE;
      data_n  = rx_data;
      valid_n = 1'b0;
      eop_n   = 1'b0;
      err_n   = 1'b0;
    end
  end

  always_ff @(posedge clk48 or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      zero_cnt  <= 3'd0;
      bit_cnt   <= 3'd0;
      ones_cnt  <= 3'd0;
      idle_cnt  <= 3'd0;
      shift_q   <= 8'h00;
      prev_j    <= 1'b1;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_eop    <= 1'b0;
      rx_err    <= 1'b0;
      rx_active <= 1'b0;
    end else begin
      state     <= state_n;
      zero_cnt  <= zero_n;
      bit_cnt   <= bit_n;
      ones_cnt  <= ones_n;
      idle_cnt  <= idle_n;
      shift_q   <= shift_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
      rx_eop    <= eop_n;
      rx_err    <= err_n;
      rx_active <= (state_n == DATA) || (state_n == EOP);
      if (sample && !se0_sync)
        prev_j <= j_sync;
      else if (state == IDLE)
        prev_j <= 1'b1;
    end
  end

endmodule

// File: tb/tb_usb_fs_rx.sv
// tb_usb_fs_rx: table-driven packet vectors for usb_fs_rx plus hand-written
// sequences for bus reset, tx_en blanking and reset mid-packet.
module tb_usb_fs_rx;

  localparam int SYM_K   = 0;
  localparam int SYM_J   = 1;
  localparam int SYM_SE0 = 2;

  logic       clk48 = 1'b0;
  logic       rst;
  logic       tx_en;
  logic       rx_j;
  logic       rx_se0;
  logic       rx_active;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_eop;
  logic       rx_err;
  logic       usb_rst;

  always #10 clk48 = ~clk48;

  usb_fs_rx dut (
    .clk48    (clk48),
    .rst      (rst),
    .tx_en    (tx_en),
    .rx_j     (rx_j),
    .rx_se0   (rx_se0),
    .rx_active(rx_active),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_eop   (rx_eop),
    .rx_err   (rx_err),
    .usb_rst  (usb_rst)
  );

  typedef struct {
    string      name;
    int         kind;       // 0 packet+EOP, 1 seven ones, 2 bad SYNC, 3 K after SE0
    int         nBytes;
    logic [7:0] b0;
    logic [7:0] b1;
    int         extraBits;
    bit         jitter;
    int         expValid;
    logic [7:0] expD0;
    logic [7:0] expD1;
    int         expEop;
    int         expErr;
    bit         expActive;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Cumulative monitor; only this block writes these, tests snapshot bases.
  logic [7:0] byteLog[$];
  int validTotal = 0, eopTotal = 0, errTotal = 0, violTotal = 0, activeTotal = 0;
  int eopSinceMark = 0;
  always @(negedge clk48) begin
    if (rx_valid) begin
      byteLog.push_back(rx_data);
      validTotal++;
    end
    if (rx_eop) eopTotal++;
    if (rx_err) begin
      errTotal++;
      if (rx_valid || rx_eop) violTotal++;
    end
    if (rx_active) activeTotal++;
  end

  int baseByte, baseValid, baseEop, baseErr, baseViol, baseActive;
  int symQ[$];
  logic curLevel;
  int onesRun;

  task automatic markStart();
    baseByte   = byteLog.size();
    baseValid  = validTotal;
    baseEop    = eopTotal;
    baseErr    = errTotal;
    baseViol   = violTotal;
    baseActive = activeTotal;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic addSym(input int s, input int n);
    for (int i = 0; i < n; i++) symQ.push_back(s);
  endtask

  task automatic addSync();
    for (int i = 0; i < 7; i++) symQ.push_back((i % 2 == 1) ? SYM_J : SYM_K);
    symQ.push_back(SYM_K);
    curLevel = 1'b0;
    onesRun  = 0;
  endtask

  // NRZI-encodes one bit; with stuffing on, a toggle follows every six ones.
  task automatic addBit(input bit b, input bit stuff);
    if (!b) curLevel = ~curLevel;
    symQ.push_back(curLevel ? SYM_J : SYM_K);
    if (stuff) begin
      onesRun = b ? onesRun + 1 : 0;
      if (onesRun == 6) begin
        curLevel = ~curLevel;
        symQ.push_back(curLevel ? SYM_J : SYM_K);
        onesRun = 0;
      end
    end
  endtask

  task automatic addByte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) addBit(b[i], 1'b1);
  endtask

  // Jittered durations keep every edge 0..+1 clock late of nominal, so each
  // bit is 3, 4 or 5 clocks long while the drift never accumulates.
  task automatic sendSyms(input bit jitter);
    int offset;
    int dur;
    offset = 0;
    foreach (symQ[i]) begin
      rx_se0 = (symQ[i] == SYM_SE0);
      rx_j   = (symQ[i] == SYM_J);
      dur = 4;
      if (jitter) begin
        if (offset == 0) begin
          dur = 4 + int'($urandom_range(0, 1));
          if (dur == 5) offset = 1;
        end else begin
          dur = 3 + int'($urandom_range(0, 1));
          if (dur == 3) offset = 0;
        end
      end
      repeat (dur) @(negedge clk48);
    end
    symQ.delete();
  endtask

  task automatic applyStimulus(input vec_t v);
    addSym(SYM_J, 10);
    if (v.kind == 2) begin
      addSym(SYM_K, 2);
    end else begin
      addSync();
      if (v.kind == 1) begin
        for (int i = 0; i < 7; i++) addBit(1'b1, 1'b0);
      end else begin
        if (v.nBytes >= 1) addByte(v.b0);
        if (v.nBytes >= 2) addByte(v.b1);
        for (int i = 0; i < v.extraBits; i++) addBit(1'b0, 1'b1);
        if (v.kind == 3) begin
          addSym(SYM_SE0, 1);
          addSym(SYM_K, 1);
        end else begin
          addSym(SYM_SE0, 2);
        end
      end
    end
    addSym(SYM_J, 12);
    sendSyms(v.jitter);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"ack",          0, 1, 8'hD2, 8'h00, 0, 1'b0, 1, 8'hD2, 8'h00, 1, 0, 1'b1};
    vecs[1] = '{"ack_jitter",   0, 1, 8'hD2, 8'h00, 0, 1'b1, 1, 8'hD2, 8'h00, 1, 0, 1'b1};
    vecs[2] = '{"stuff",        0, 2, 8'hFF, 8'h01, 0, 1'b0, 2, 8'hFF, 8'h01, 1, 0, 1'b1};
    vecs[3] = '{"stuff_jitter", 0, 2, 8'hFF, 8'h01, 0, 1'b1, 2, 8'hFF, 8'h01, 1, 0, 1'b1};
    vecs[4] = '{"two_bytes",    0, 2, 8'h00, 8'hA5, 0, 1'b0, 2, 8'h00, 8'hA5, 1, 0, 1'b1};
    vecs[5] = '{"misaligned",   0, 1, 8'hC3, 8'h00, 4, 1'b0, 1, 8'hC3, 8'h00, 0, 1, 1'b1};
    vecs[6] = '{"dribble",      0, 1, 8'hC3, 8'h00, 1, 1'b0, 1, 8'hC3, 8'h00, 1, 0, 1'b1};
    vecs[7] = '{"stuff_err",    1, 0, 8'h00, 8'h00, 0, 1'b0, 0, 8'h00, 8'h00, 0, 1, 1'b1};
    vecs[8] = '{"bad_sync",     2, 0, 8'h00, 8'h00, 0, 1'b0, 0, 8'h00, 8'h00, 0, 1, 1'b0};
    vecs[9] = '{"k_after_se0",  3, 1, 8'hD2, 8'h00, 0, 1'b0, 1, 8'hD2, 8'h00, 0, 1, 1'b1};

    rst    = 1'b1;
    tx_en  = 1'b0;
    rx_j   = 1'b1;
    rx_se0 = 1'b0;
    #2 rst = 1'b0;
    #5;
    checkOutput("reset.rx_active", int'(rx_active), 0);
    checkOutput("reset.rx_data",   int'(rx_data),   8'h00);
    checkOutput("reset.rx_valid",  int'(rx_valid),  0);
    checkOutput("reset.rx_eop",    int'(rx_eop),    0);
    checkOutput("reset.rx_err",    int'(rx_err),    0);
    checkOutput("reset.usb_rst",   int'(usb_rst),   0);
    @(negedge clk48);
    rst = 1'b1;
    repeat (8) @(negedge clk48);

    for (int v = 0; v < 10; v++) begin
      markStart();
      applyStimulus(vecs[v]);
      checkOutput({vecs[v].name, ".valid_count"}, validTotal - baseValid, vecs[v].expValid);
      if (validTotal - baseValid >= 1 && vecs[v].expValid >= 1)
        checkOutput({vecs[v].name, ".byte0"}, int'(byteLog[baseByte]), int'(vecs[v].expD0));
      if (validTotal - baseValid >= 2 && vecs[v].expValid >= 2)
        checkOutput({vecs[v].name, ".byte1"}, int'(byteLog[baseByte + 1]), int'(vecs[v].expD1));
      checkOutput({vecs[v].name, ".eop_count"}, eopTotal - baseEop, vecs[v].expEop);
      checkOutput({vecs[v].name, ".err_count"}, errTotal - baseErr, vecs[v].expErr);
      checkOutput({vecs[v].name, ".active_seen"}, int'(activeTotal > baseActive), int'(vecs[v].expActive));
      checkOutput({vecs[v].name, ".strobe_overlap"}, violTotal - baseViol, 0);
      checkOutput({vecs[v].name, ".active_end"}, int'(rx_active), 0);
    end

    // Bus reset: SE0 held 130 clocks; usb_rst rises after 120 + 2 sync clocks.
    markStart();
    rx_se0 = 1'b1;
    rx_j   = 1'b0;
    repeat (121) @(negedge clk48);
    checkOutput("busrst.low_at_121", int'(usb_rst), 0);
    @(negedge clk48);
    checkOutput("busrst.high_at_122", int'(usb_rst), 1);
    repeat (8) @(negedge clk48);
    checkOutput("busrst.held", int'(usb_rst), 1);
    rx_se0 = 1'b0;
    rx_j   = 1'b1;
    repeat (2) @(negedge clk48);
    checkOutput("busrst.still_high_sync", int'(usb_rst), 1);
    @(negedge clk48);
    checkOutput("busrst.fall", int'(usb_rst), 0);
    checkOutput("busrst.no_err", errTotal - baseErr, 0);
    repeat (40) @(negedge clk48);

    // Our own transmitter active: a full ACK must produce nothing.
    markStart();
    tx_en = 1'b1;
    applyStimulus(vecs[0]);
    tx_en = 1'b0;
    checkOutput("txen.valid_count", validTotal - baseValid, 0);
    checkOutput("txen.eop_count",   eopTotal - baseEop,     0);
    checkOutput("txen.err_count",   errTotal - baseErr,     0);
    checkOutput("txen.active_seen", int'(activeTotal > baseActive), 0);
    checkOutput("txen.data_held",   int'(rx_data), 8'hD2);

    // Reset mid-byte: SYNC plus four bits of 0xD2, then rst low.
    addSym(SYM_J, 10);
    addSync();
    for (int i = 0; i < 4; i++) addBit(vecs[0].b0[i], 1'b1);
    sendSyms(1'b0);
    checkOutput("midrst.active_before", int'(rx_active), 1);
    markStart();
    rst = 1'b0;
    #1;
    checkOutput("midrst.rx_active", int'(rx_active), 0);
    checkOutput("midrst.rx_data",   int'(rx_data),   8'h00);
    checkOutput("midrst.rx_valid",  int'(rx_valid),  0);
    checkOutput("midrst.rx_eop",    int'(rx_eop),    0);
    checkOutput("midrst.rx_err",    int'(rx_err),    0);
    checkOutput("midrst.usb_rst",   int'(usb_rst),   0);
    rx_j = 1'b1;
    repeat (5) @(negedge clk48);
    rst = 1'b1;
    addSym(SYM_J, 20);
    sendSyms(1'b0);
    checkOutput("midrst.valid_after", validTotal - baseValid, 0);
    checkOutput("midrst.eop_after",   eopTotal - baseEop,     0);
    checkOutput("midrst.err_after",   errTotal - baseErr,     0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
